// File: rtl/traffic_pkg.sv
// rtl/traffic_pkg.sv - shared types, lamp patterns and phase sequencing for the traffic controller
//
// Purpose : phase enum, 8-bit lamp vectors per phase (bit order AG AY AR AL BG BY BR BL,
//           AG in bit 7) and the fixed phase successor function.
// Ports   : none (package).
package traffic_pkg;

    typedef enum logic [2:0] {
        A_GRN  = 3'd0,
        A_YEL1 = 3'd1,
        A_LFT  = 3'd2,
        A_YEL2 = 3'd3,
        B_GRN  = 3'd4,
        B_YEL1 = 3'd5,
        B_LFT  = 3'd6,
        B_YEL2 = 3'd7
    } phase_e;

    //                                        AG AY AR AL BG BY BR BL
    localparam logic [7:0] LAMP_A_GRN  = 8'b1__0__0__0__0__0__1__0;
    localparam logic [7:0] LAMP_A_YEL1 = 8'b0__1__0__0__0__0__1__0;
    localparam logic [7:0] LAMP_A_LFT  = 8'b0__0__1__1__0__0__1__0;
    localparam logic [7:0] LAMP_A_YEL2 = 8'b0__1__0__0__0__0__1__0;
    localparam logic [7:0] LAMP_B_GRN  = 8'b0__0__1__0__1__0__0__0;
    localparam logic [7:0] LAMP_B_YEL1 = 8'b0__0__1__0__0__1__0__0;
    localparam logic [7:0] LAMP_B_LFT  = 8'b0__0__1__0__0__0__1__1;
    localparam logic [7:0] LAMP_B_YEL2 = 8'b0__0__1__0__0__1__0__0;

    // Flash mode lights only the two yellows, both driven by the blink bit.
    localparam logic [7:0] LAMP_FLASH  = 8'b0__1__0__0__0__1__0__0;

    function automatic phase_e next_phase(input phase_e p);
        phase_e n;
        case (p)
            A_GRN:   n = A_YEL1;
            A_YEL1:  n = A_LFT;
            A_LFT:   n = A_YEL2;
            A_YEL2:  n = B_GRN;
            B_GRN:   n = B_YEL1;
            B_YEL1:  n = B_LFT;
            B_LFT:   n = B_YEL2;
            default: n = A_GRN;
        endcase
        return n;
    endfunction

    function automatic logic [7:0] lamps_of(input phase_e p);
        logic [7:0] l;
        case (p)
            A_GRN:   l = LAMP_A_GRN;
            A_YEL1:  l = LAMP_A_YEL1;
            A_LFT:   l = LAMP_A_LFT;
            A_YEL2:  l = LAMP_A_YEL2;
            B_GRN:   l = LAMP_B_GRN;
            B_YEL1:  l = LAMP_B_YEL1;
            B_LFT:   l = LAMP_B_LFT;
            default: l = LAMP_B_YEL2;
        endcase
        return l;
    endfunction

endpackage

// File: rtl/tick_prescaler.sv
// rtl/tick_prescaler.sv - divides clk into a one-cycle tick every TICK_DIV cycles
//
// Purpose : counter runs 0..TICK_DIV-1 and asserts tick_o while it holds TICK_DIV-1.
// Ports   : clk_i   - clock, rising edge
//           rst_ni  - asynchronous active-low reset (counter to 0)
//           clr_i   - synchronous restart of the count at 0
//           tick_o  - tick strobe
module tick_prescaler #(
    parameter int TICK_DIV = 1
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clr_i,
    output logic tick_o
);

    localparam int W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [W-1:0] LAST = W'(TICK_DIV - 1);

    if (TICK_DIV < 1) begin : g_bad_div
        $error("tick_prescaler: TICK_DIV must be at least 1");
    end

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    assign tick_o = (cnt_q == LAST);

    always_comb begin
        cnt_d = cnt_q + W'(1);
        if (clr_i || tick_o) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/traffic_controller_param.sv
// rtl/traffic_controller_param.sv - parametrised two-road intersection controller with night flash
//
// Purpose : steps A_GRN..B_YEL2 with per-phase countdown, decodes lamps from the registered
//           phase, toggles a night-flash mode on each synchronised ctrl_btn rising edge.
//           Optional macro TRAFFIC_PED_REQ_EN adds ped_req, which shortens A green to PED_MIN.
// Ports   : clk        - clock, rising edge
//           reset      - asynchronous active-low reset
//           ctrl_btn   - raw flash toggle button
//           ped_req    - pedestrian request (TRAFFIC_PED_REQ_EN only)
//           countdown  - remaining ticks of current phase, 0 while flashing
//           phase      - current phase index
//           AG AY AR AL BG BY BR BL - lamp drives
module traffic_controller_param
    import traffic_pkg::*;
#(
    parameter int CNT_W    = 6,
    parameter int T_GREEN  = 30,
    parameter int T_LEFT   = 15,
    parameter int T_YELLOW = 3,
    parameter int TICK_DIV = 1,
    parameter int PED_MIN  = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ctrl_btn,
`ifdef TRAFFIC_PED_REQ_EN
    input  logic             ped_req,
`endif
    output logic [CNT_W-1:0] countdown,
    output logic [2:0]       phase,
    output logic             AG,
    output logic             AY,
    output logic             AR,
    output logic             AL,
    output logic             BG,
    output logic             BY,
    output logic             BR,
    output logic             BL
);

    localparam int CNT_MAX = (1 << CNT_W) - 1;

    if (T_GREEN < 1 || T_GREEN > CNT_MAX || T_LEFT < 1 || T_LEFT > CNT_MAX ||
        T_YELLOW < 1 || T_YELLOW > CNT_MAX || TICK_DIV < 1 ||
        PED_MIN < 0 || PED_MIN > CNT_MAX) begin : g_bad_param
        $error("traffic_controller_param: parameter out of range");
    end

    function automatic logic [CNT_W-1:0] dur_of(input phase_e p);
        logic [CNT_W-1:0] d;
        case (p)
            A_GRN, B_GRN: d = CNT_W'(T_GREEN);
            A_LFT, B_LFT: d = CNT_W'(T_LEFT);
            default:      d = CNT_W'(T_YELLOW);
        endcase
        return d;
    endfunction

    phase_e           phase_q, phase_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             flash_q, flash_d;
    logic             blink_q, blink_d;
    logic             btn_s1_q, btn_s2_q, btn_s3_q;
    logic             btn_rise;
    logic             flash_enter, flash_exit;
    logic             tick;
    logic [7:0]       lamps;

    // btn_s3_q is the previous synchronised value, used only for edge detection.
    assign btn_rise    = btn_s2_q & ~btn_s3_q;
    assign flash_enter = btn_rise & ~flash_q;
    assign flash_exit  = btn_rise & flash_q;

    tick_prescaler #(
        .TICK_DIV (TICK_DIV)
    ) u_prescaler (
        .clk_i  (clk),
        .rst_ni (reset),
        .clr_i  (flash_exit),
        .tick_o (tick)
    );

`ifdef TRAFFIC_PED_REQ_EN
    logic ped_q;
    logic pend_q, pend_d;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            phase_q  <= A_GRN;
            cnt_q    <= CNT_W'(T_GREEN);
            flash_q  <= 1'b0;
            blink_q  <= 1'b0;
            btn_s1_q <= 1'b0;
            btn_s2_q <= 1'b0;
            btn_s3_q <= 1'b0;
`ifdef TRAFFIC_PED_REQ_EN
            ped_q    <= 1'b0;
            pend_q   <= 1'b0;
`endif
        end else begin
            phase_q  <= phase_d;
            cnt_q    <= cnt_d;
            flash_q  <= flash_d;
            blink_q  <= blink_d;
            btn_s1_q <= ctrl_btn;
            btn_s2_q <= btn_s1_q;
            btn_s3_q <= btn_s2_q;
`ifdef TRAFFIC_PED_REQ_EN
            ped_q    <= ped_req;
            pend_q   <= pend_d;
`endif
        end
    end

    always_comb begin
        phase_d = phase_q;
        cnt_d   = cnt_q;
        flash_d = flash_q ^ btn_rise;
        blink_d = blink_q;
        if (flash_exit) begin
            phase_d = A_GRN;
            cnt_d   = CNT_W'(T_GREEN);
            blink_d = 1'b0;
        end else if (flash_enter) begin
            // Phase and countdown freeze; yellows come on immediately.
            blink_d = 1'b1;
        end else if (flash_q) begin
            if (tick) begin
                blink_d = ~blink_q;
            end
        end else if (tick) begin
`ifdef TRAFFIC_PED_REQ_EN
            if (pend_q && (cnt_q > CNT_W'(PED_MIN))) begin
                cnt_d = CNT_W'(PED_MIN);
            end else
`endif
            if (cnt_q > CNT_W'(1)) begin
                cnt_d = cnt_q - CNT_W'(1);
            end else begin
                phase_d = next_phase(phase_q);
                cnt_d   = dur_of(phase_d);
            end
        end
    end

`ifdef TRAFFIC_PED_REQ_EN
    // Pending survives only while the controller stays in normal-mode A_GRN.
    always_comb begin
        pend_d = 1'b0;
        if (!flash_q && !btn_rise && phase_q == A_GRN && phase_d == A_GRN) begin
            pend_d = pend_q | ped_q;
        end
    end
`endif

    always_comb begin
        lamps     = lamps_of(phase_q);
        countdown = cnt_q;
        if (flash_q) begin
            lamps     = blink_q ? LAMP_FLASH : 8'h00;
            countdown = '0;
        end
    end

    assign phase = phase_q;
    assign {AG, AY, AR, AL, BG, BY, BR, BL} = lamps;

endmodule

// File: tb/tb_traffic_controller_param.sv
// tb/tb_traffic_controller_param.sv - directed self-checking bench for traffic_controller_param
module tb_traffic_controller_param;

    logic clk = 1'b0;
    logic reset;
    logic ctrl_btn;
    logic ped_req;

    always #5 clk = ~clk;

    logic [5:0] cd1, cd4;
    logic [2:0] ph1, ph4;
    logic AG1, AY1, AR1, AL1, BG1, BY1, BR1, BL1;
    logic AG4, AY4, AR4, AL4, BG4, BY4, BR4, BL4;
    logic [7:0] l1;
    assign l1 = {AG1, AY1, AR1, AL1, BG1, BY1, BR1, BL1};

    traffic_controller_param #(
        .CNT_W(6), .T_GREEN(4), .T_LEFT(2), .T_YELLOW(1), .TICK_DIV(1), .PED_MIN(5)
    ) dut1 (
        .clk(clk), .reset(reset), .ctrl_btn(ctrl_btn),
`ifdef TRAFFIC_PED_REQ_EN
        .ped_req(1'b0),
`endif
        .countdown(cd1), .phase(ph1),
        .AG(AG1), .AY(AY1), .AR(AR1), .AL(AL1), .BG(BG1), .BY(BY1), .BR(BR1), .BL(BL1)
    );

    traffic_controller_param #(
        .CNT_W(6), .T_GREEN(4), .T_LEFT(2), .T_YELLOW(1), .TICK_DIV(4), .PED_MIN(5)
    ) dut4 (
        .clk(clk), .reset(reset), .ctrl_btn(ctrl_btn),
`ifdef TRAFFIC_PED_REQ_EN
        .ped_req(1'b0),
`endif
        .countdown(cd4), .phase(ph4),
        .AG(AG4), .AY(AY4), .AR(AR4), .AL(AL4), .BG(BG4), .BY(BY4), .BR(BR4), .BL(BL4)
    );

`ifdef TRAFFIC_PED_REQ_EN
    logic [5:0] cdp;
    logic [2:0] php;
    logic AGp, AYp, ARp, ALp, BGp, BYp, BRp, BLp;
    traffic_controller_param #(
        .CNT_W(6), .T_GREEN(30), .T_LEFT(15), .T_YELLOW(3), .TICK_DIV(1), .PED_MIN(5)
    ) dutp (
        .clk(clk), .reset(reset), .ctrl_btn(1'b0), .ped_req(ped_req),
        .countdown(cdp), .phase(php),
        .AG(AGp), .AY(AYp), .AR(ARp), .AL(ALp), .BG(BGp), .BY(BYp), .BR(BRp), .BL(BLp)
    );
`endif

    int n_checks = 0;
    int n_fail   = 0;
    int k        = 0;

    int         exp_ph[17] = '{0, 0, 0, 0, 1, 2, 2, 3, 4, 4, 4, 4, 5, 6, 6, 7, 0};
    int         exp_cd[17] = '{4, 3, 2, 1, 1, 2, 1, 1, 4, 3, 2, 1, 1, 2, 1, 1, 4};
    logic [7:0] lamp_tab[8] = '{8'h82, 8'h42, 8'h32, 8'h42, 8'h28, 8'h24, 8'h23, 8'h24};

    task automatic check(input string tag, input int unsigned got, input int unsigned exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s (k=%0d): got %0d expected %0d", tag, k, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        k++;
    endtask

    initial begin
        reset    = 1'b0;
        ctrl_btn = 1'b0;
        ped_req  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_phase", ph1, 0);
        check("rst_cd", cd1, 4);
        check("rst_lamps", l1, 8'h82);
        check("rst_cd_div4", cd4, 4);

        reset = 1'b1;
        k = 0;
        for (int i = 1; i <= 16; i++) begin
            step();
            check("cyc_phase", ph1, exp_ph[i]);
            check("cyc_cd", cd1, exp_cd[i]);
            check("cyc_lamps", l1, lamp_tab[exp_ph[i]]);
            check("div4_phase", ph4, (i < 16) ? 0 : 1);
            check("div4_cd", cd4, (i < 16) ? (4 - i / 4) : 1);
        end

        // Flash entry: button rises during B_LFT (k=29), held for three edges.
        while (k < 29) step();
        check("pre_flash_phase", ph1, 6);
        ctrl_btn = 1'b1;
        step();
        step();
        check("sync_lamps", l1, 8'h24);
        check("sync_cd", cd1, 1);
        step();
        ctrl_btn = 1'b0;
        check("flash_phase_hold", ph1, 7);
        for (int i = 0; i < 4; i++) begin
            if (i > 0) step();
            check("flash_lamps", l1, (i % 2 == 0) ? 8'h44 : 8'h00);
            check("flash_cd", cd1, 0);
        end

        // Flash exit.
        while (k < 36) step();
        ctrl_btn = 1'b1;
        step();
        step();
        check("exit_wait_cd", cd1, 0);
        step();
        ctrl_btn = 1'b0;
        check("exit_phase", ph1, 0);
        check("exit_cd", cd1, 4);
        check("exit_lamps", l1, 8'h82);
        step();
        check("exit_first_tick", cd1, 3);

        // Button held for 20 cycles gives one toggle.
        ctrl_btn = 1'b1;
        step();
        step();
        check("hold_pre_cd", cd1, 1);
        check("hold_pre_lamps", l1, 8'h82);
        step();
        check("hold_enter_cd", cd1, 0);
        check("hold_enter_lamps", l1, 8'h44);
        while (k < 60) begin
            step();
            check("hold_cd", cd1, 0);
            check("hold_lamps", l1, ((k - 43) % 2 == 0) ? 8'h44 : 8'h00);
        end
        ctrl_btn = 1'b0;
        repeat (5) step();
        check("release_cd", cd1, 0);
        check("release_lamps", l1, 8'h44);

        // Asynchronous reset mid-cycle in B_YEL2.
        reset = 1'b0;
        step();
        step();
        reset = 1'b1;
        k = 0;
        repeat (15) step();
        check("pre_areset_phase", ph1, 7);
        check("pre_areset_cd", cd1, 1);
        #2;
        reset = 1'b0;
        #1;
        check("areset_phase", ph1, 0);
        check("areset_cd", cd1, 4);
        check("areset_lamps", l1, 8'h82);
        check("areset_cd_div4", cd4, 4);

`ifdef TRAFFIC_PED_REQ_EN
        @(posedge clk);
        #1;
        reset = 1'b1;
        k = 0;
        while (k < 10) step();
        check("ped_pre_cd", cdp, 20);
        ped_req = 1'b1;
        step();
        ped_req = 1'b0;
        step();
        step();
        check("ped_short_cd", cdp, 5);
        step();
        check("ped_short_next", cdp, 4);

        reset = 1'b0;
        step();
        reset = 1'b1;
        k = 0;
        while (k < 27) step();
        check("ped_low_pre", cdp, 3);
        ped_req = 1'b1;
        step();
        ped_req = 1'b0;
        step();
        check("ped_low_cd", cdp, 1);
        step();
        check("ped_low_phase", php, 1);
        check("ped_low_yel_cd", cdp, 3);

        while (k < 51) step();
        check("ped_bgrn_phase", php, 4);
        check("ped_bgrn_pre", cdp, 30);
        ped_req = 1'b1;
        step();
        ped_req = 1'b0;
        repeat (3) step();
        check("ped_bgrn_ignored", cdp, 26);
        check("ped_bgrn_phase2", php, 4);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/traffic_controller_param.md
Name: traffic_controller_param

Overview:
- Parametrised two-road (A/B) intersection controller with green, yellow, red and left-turn lamps per road, plus a per-phase countdown for the display.
- Successor to the fixed-timing controller: phase durations, countdown width and tick rate are parameters.
- Adds a night-flash mode toggled by ctrl_btn.
- Sits between the board clock and the lamp/7-segment drivers.

Parameters:
- CNT_W, 6, countdown width in bits.
- T_GREEN, 30, straight-green duration in ticks.
- T_LEFT, 15, left-turn duration in ticks.
- T_YELLOW, 3, duration in ticks of each yellow phase.
- TICK_DIV, 1, clk cycles per tick (1 = every cycle).
- PED_MIN, 5, remaining green after a pedestrian request (optional feature only).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- ctrl_btn  in  1  raw button; each rising edge toggles night-flash mode.
- countdown  out  CNT_W  remaining ticks of the current phase; 0 in flash mode.
- phase  out  3  current phase index (package enum).
- AG  out  1  A green.
- AY  out  1  A yellow.
- AR  out  1  A red.
- AL  out  1  A left arrow.
- BG  out  1  B green.
- BY  out  1  B yellow.
- BR  out  1  B red.
- BL  out  1  B left arrow.
- ped_req  in  1  pedestrian request for road B crossing (present only with the macro).

Behaviour:
- Reset (reset=0, async):
  - phase=A_GRN, countdown=T_GREEN, prescaler=0, flash=0, synchroniser flops=0.
  - Lamps: AG=1, BR=1, all other lamps 0.
- Tick: the prescaler counts 0..TICK_DIV-1 and asserts tick in the cycle it holds TICK_DIV-1, then wraps to 0.
- Phase cycle, fixed order: A_GRN -> A_YEL1 -> A_LFT -> A_YEL2 -> B_GRN -> B_YEL1 -> B_LFT -> B_YEL2 -> A_GRN.
- Durations: GRN=T_GREEN, LFT=T_LEFT, YEL1/YEL2=T_YELLOW.
- Countdown rules:
  - On each tick, if countdown>1, decrement.
  - If countdown==1, advance the phase and load the next phase's duration in the same edge.
  - Each phase therefore lasts exactly duration ticks, and the display shows duration..1.
- Lamp decode (Moore, from the registered phase; all unlisted lamps 0):
  - A_GRN: AG, BR.
  - A_YEL1: AY, BR.
  - A_LFT: AL, AR, BR.
  - A_YEL2: AY, BR.
  - B phases mirror A with the roads swapped.
  - Exactly one of {G, Y, R} is lit per road in every non-flash phase.
- ctrl_btn handling:
  - Two-flop synchroniser, then a rising-edge detect on the synchronised value.
  - flash toggles on the edge 3 clk edges after the button rises.
  - Holding the button gives a single toggle.
- Flash mode:
  - All G/R/L lamps=0.
  - AY=BY=blink bit, which toggles every tick and starts at 1 on entry.
  - countdown=0; phase holds its last value.
- Flash exit: phase=A_GRN, countdown=T_GREEN, prescaler=0, blink=0.
- Reset mid-phase or mid-flash returns to the reset state immediately, with no wait for a clk edge.
- Elaboration error if any duration is 0 or exceeds 2**CNT_W-1, or if TICK_DIV<1.

Optional Feature:
- Macro: TRAFFIC_PED_REQ_EN.
- Defined:
  - ped_req port exists and is registered once.
  - A request seen during A_GRN (road A traffic crossing B's pedestrians) sets a latched pending flag.
  - On the next tick, if countdown>PED_MIN, countdown loads PED_MIN; otherwise no change.
  - pending clears on leaving A_GRN or on reset.
  - Requests in other phases or in flash mode are ignored.
- Undefined: the port is absent and timing is purely parameter-driven.

Decomposition:
- Package traffic_pkg:
  - phase enum: A_GRN=0, A_YEL1=1, A_LFT=2, A_YEL2=3, B_GRN=4, B_YEL1=5, B_LFT=6, B_YEL2=7.
  - 8-bit lamp-vector constants per phase, in order AG AY AR AL BG BY BR BL.
  - A next_phase function.
- One sub-module, tick_prescaler (parameter TICK_DIV, outputs tick), reused by the display driver.

Test Plan:
1. Reset and full cycle (T_GREEN=4, T_LEFT=2, T_YELLOW=1, TICK_DIV=1):
   - Stimulus: reset low for 2 cycles, then release.
   - Required: AG=1, BR=1, countdown 4,3,2,1, then A_YEL1 (AY=1, countdown 1), then A_LFT (AL=AR=BR=1, countdown 2,1).
   - Required: back to A_GRN after 16 cycles.
2. Prescaler (TICK_DIV=4, same durations):
   - Required: countdown changes every 4 clk cycles.
   - Required: A_GRN lasts 16 cycles; the first decrement lands on cycle 4 after release.
3. Flash mode:
   - Stimulus: ctrl_btn pulse (3 cycles high) during B_LFT.
   - Required: flash after 3 edges; all G/R/L=0; AY=BY toggling each tick starting at 1; countdown=0.
   - Stimulus: second pulse.
   - Required: A_GRN with countdown=4.
4. Asynchronous reset:
   - Stimulus: reset asserted mid-cycle during B_YEL2 with countdown=1.
   - Required: outputs go to the reset values before the next clk edge.
5. Button hold:
   - Stimulus: ctrl_btn held high for 20 cycles.
   - Required: exactly one toggle into flash.
6. TRAFFIC_PED_REQ_EN (T_GREEN=30, PED_MIN=5):
   - ped_req pulse at countdown=20 in A_GRN -> countdown becomes 5 on the next tick.
   - ped_req pulse at countdown=3 -> no change.
   - ped_req pulse in B_GRN -> ignored.
